rx_fifo_drain: RTL

Read-side consumer of the receive FIFO in the macPIRxClk domain. It pops 36-bit words (32 data + 4-bit MPDU delimiter tag) from the rx FIFO read interface, handles the one-cycle read latency with a 2-entry skid buffer, and parses tags into MPDU boundaries. It presents a valid/ready word stream with first/last/discard markers to the RX DMA write engine, counts words per MPDU, and can flush the FIFO on abort.

---
 rtl/rx_fifo_drain.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_fifo_drain.sv
// Receive FIFO read-side drain: skid-buffered pops, MPDU tag parsing, DMA word stream.
// Optional length limit enabled by defining RX_DRAIN_LENCHECK_EN.
module rx_fifo_drain #(
    parameter int unsigned MAX_WORDS = 2866
) (
    input  logic        macPIRxClk,
    input  logic        macPIClkSoftRst,
    input  logic        rxDrainEn,
    input  logic        rxDrainAbort,
    input  logic        rxFIFOEmpty,
    input  logic        rxFIFOAlmEmpty,
    input  logic        rxFIFODataValid,
    input  logic [31:0] rxFIFORdData,
    input  logic [3:0]  rxFIFOMPDUDelimiters,
    output logic        rxFIFORead,
    output logic        rxFIFORdFlush,
    output logic        dmaWrValid,
    input  logic        dmaWrReady,
    output logic [31:0] dmaWrData,
    output logic        dmaWrFirst,
    output logic        dmaWrLast,
    output logic        dmaWrDiscard,
    output logic [15:0] mpduWordCnt,
    output logic        mpduDone,
    output logic        tagError,
    output logic        lenError,
    output logic        drainBusy
);

    localparam logic [3:0] TagStart  = 4'h1;
    localparam logic [3:0] TagEndOk  = 4'h2;
    localparam logic [3:0] TagEndBad = 4'h3;

    typedef enum logic [0:0] {StIdle, StInMpdu} state_e;

    state_e      state_q, st_d;
    logic [35:0] buf_q [2];
    logic [1:0]  buf_cnt_q;
    logic        rd_q;
    logic        flush_q;
    logic [15:0] cnt_q, cnt_d, cnt_out, cnt_inc;
    logic        len_hit_q, hit_d;

    logic [3:0]  head_tag;
    logic        is_start, is_end, is_rsv;
    logic        has_head, drop, pop, cap;
    logic        first, last, discard, tag_err, len_err;
    logic [35:0] wr_word;

    assign head_tag = buf_q[0][35:32];
    assign is_start = (head_tag == TagStart);
    assign is_end   = (head_tag == TagEndOk) || (head_tag == TagEndBad);
    assign is_rsv   = (head_tag > TagEndBad);
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign wr_word  = {rxFIFOMPDUDelimiters, rxFIFORdData};

    // Nothing is presented or captured while the flush is in progress.
    assign has_head = (buf_cnt_q != 2'd0) && !flush_q;
    assign pop      = has_head && (drop || dmaWrReady);
    assign cap      = rxFIFODataValid && !flush_q;

    assign rxFIFORead = rxDrainEn && !rxFIFOEmpty && !flush_q &&
                        (({1'b0, buf_cnt_q} + {2'b00, rd_q}) < 3'd2) &&
                        !(rxFIFOAlmEmpty && rd_q);

`ifdef RX_DRAIN_LENCHECK_EN
    logic at_max;
    assign at_max = (32'(cnt_q) >= MAX_WORDS);
`endif

    always_comb begin
        drop    = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        discard = 1'b0;
        tag_err = 1'b0;
        len_err = 1'b0;
        cnt_out = cnt_q;
        st_d    = state_q;
        cnt_d   = cnt_q;
        hit_d   = len_hit_q;
        case (state_q)
            StIdle: begin
                if (is_start) begin
                    first   = 1'b1;
                    cnt_out = 16'd1;
                    st_d    = StInMpdu;
                    cnt_d   = 16'd1;
                    hit_d   = 1'b0;
                end else begin
                    drop    = 1'b1;
                    tag_err = 1'b1;
                end
            end
            StInMpdu: begin
                if (is_start) begin
                    // Unexpected START: report it and restart the MPDU on this word.
                    first   = 1'b1;
                    tag_err = 1'b1;
                    cnt_out = 16'd1;
                    cnt_d   = 16'd1;
                    hit_d   = 1'b0;
                end else if (is_end) begin
                    last    = 1'b1;
                    discard = (head_tag == TagEndBad);
                    cnt_out = cnt_inc;
                    st_d    = StIdle;
                    cnt_d   = 16'd0;
                    hit_d   = 1'b0;
`ifdef RX_DRAIN_LENCHECK_EN
                    if (at_max) begin
                        discard = 1'b1;
                        cnt_out = cnt_q;
                        len_err = !len_hit_q;
                    end
`endif
                end else begin
                    tag_err = is_rsv;
                    cnt_out = cnt_inc;
                    cnt_d   = cnt_inc;
`ifdef RX_DRAIN_LENCHECK_EN
                    if (at_max) begin
                        drop    = 1'b1;
                        cnt_out = cnt_q;
                        cnt_d   = cnt_q;
                        len_err = !len_hit_q;
                        hit_d   = 1'b1;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge macPIRxClk) begin
        if (macPIClkSoftRst) begin
            state_q   <= StIdle;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            buf_cnt_q <= 2'd0;
            rd_q      <= 1'b0;
            flush_q   <= 1'b0;
            cnt_q     <= 16'd0;
            len_hit_q <= 1'b0;
        end else begin
            rd_q    <= rxFIFORead;
            flush_q <= rxDrainAbort;
            if (flush_q) begin
                buf_cnt_q <= 2'd0;
                state_q   <= StIdle;
                cnt_q     <= 16'd0;
                len_hit_q <= 1'b0;
            end else begin
                case ({cap, pop})
                    2'b10: begin
                        if (buf_cnt_q != 2'd2) begin
                            buf_q[buf_cnt_q[0]] <= wr_word;
                            buf_cnt_q           <= buf_cnt_q + 2'd1;
                        end
                    end
                    2'b01: begin
                        buf_q[0]  <= buf_q[1];
                        buf_cnt_q <= buf_cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (buf_cnt_q == 2'd1) begin
                            buf_q[0] <= wr_word;
                        end else begin
                            buf_q[0] <= buf_q[1];
                            buf_q[1] <= wr_word;
                        end
                    end
                    default: ;
                endcase
                if (pop) begin
                    state_q   <= st_d;
                    cnt_q     <= cnt_d;
                    len_hit_q <= hit_d;
                end
            end
        end
    end

    assign rxFIFORdFlush = flush_q;
    assign dmaWrValid    = has_head && !drop;
    assign dmaWrData     = buf_q[0][31:0];
    assign dmaWrFirst    = first;
    assign dmaWrLast     = last;
    assign dmaWrDiscard  = discard;
    assign mpduWordCnt   = cnt_out;
    assign mpduDone      = dmaWrValid && dmaWrReady && last;
    assign tagError      = pop && tag_err;
    assign drainBusy     = (state_q == StInMpdu) || (buf_cnt_q != 2'd0) || rd_q;

`ifdef RX_DRAIN_LENCHECK_EN
    assign lenError = pop && len_err;
`else
    logic unused_lencheck;
    assign unused_lencheck = ^{len_err, len_hit_q, hit_d, MAX_WORDS};
    assign lenError        = 1'b0;
`endif

endmodule
